// File: rtl/skylark_dmem.sv
// Skylark data memory: 2^ADDR_W x 32 array, 1-cycle loads, and an optional
// store buffer with youngest-entry load forwarding (enable with SKYLARK_DMEM_SB_EN).
`timescale 1ns/1ps
module skylark_dmem #(
    parameter int ADDR_W   = 8,
    parameter int SB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteW,
    input  logic        MemReadW,
    input  logic [31:0] ALUResultW,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        SbFull,
    output logic        OverflowErr
);

    localparam int WORDS = 1 << ADDR_W;

    logic [31:0]       mem [WORDS];
    logic [ADDR_W-1:0] word_idx;
    logic              is_store;
    logic              is_load;
    logic              unused_addr_bits;

    assign word_idx         = ALUResultW[ADDR_W+1:2];
    assign unused_addr_bits = ^{ALUResultW[31:ADDR_W+2], ALUResultW[1:0]};
    assign is_store         = MemWriteW;
    assign is_load          = MemReadW & ~MemWriteW;

    // Array port and forwarding hooks, driven by whichever build variant is selected.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              fwd_hit;
    logic [31:0]       fwd_data;

    logic [31:0] mem_rdata_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (is_load) begin
            mem_rdata_q <= mem[word_idx];
        end
    end

    // Load result bookkeeping; rd_live_q forces ReadData to zero until the first load after reset.
    logic        read_valid_q, read_valid_d;
    logic        rd_live_q, rd_live_d;
    logic        rd_fwd_q, rd_fwd_d;
    logic [31:0] fwd_data_q, fwd_data_d;

    always_comb begin
        read_valid_d = is_load;
        rd_live_d    = rd_live_q | is_load;
        rd_fwd_d     = rd_fwd_q;
        fwd_data_d   = fwd_data_q;
        if (is_load) begin
            rd_fwd_d   = fwd_hit;
            fwd_data_d = fwd_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_valid_q <= 1'b0;
            rd_live_q    <= 1'b0;
            rd_fwd_q     <= 1'b0;
            fwd_data_q   <= '0;
        end else begin
            read_valid_q <= read_valid_d;
            rd_live_q    <= rd_live_d;
            rd_fwd_q     <= rd_fwd_d;
            fwd_data_q   <= fwd_data_d;
        end
    end

    assign ReadValid = read_valid_q;
    assign ReadData  = !rd_live_q ? 32'h0 : (rd_fwd_q ? fwd_data_q : mem_rdata_q);

`ifdef SKYLARK_DMEM_SB_EN
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SB_DEPTH);

    logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
    logic [31:0]       sb_data_q [SB_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              full;
    logic              drain;
    logic              enq;

    assign full  = (count_q == FULL_CNT);
    // MemReadW reserves the array port even in a store cycle, so a core holding
    // MemReadW high can starve draining and fill the buffer.
    assign drain = ~MemReadW & (count_q != '0);
    assign enq   = is_store & (~full | drain);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (drain) begin
            head_d = head_q + 1'b1;
        end
        if (enq) begin
            tail_d = tail_q + 1'b1;
        end
        case ({enq, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (is_store && !enq) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            sb_addr_q[tail_q] <= word_idx;
            sb_data_q[tail_q] <= WriteData;
        end
    end

    // Entries viewed by age: index 0 is the oldest (head), higher indices are younger.
    logic [PTR_W-1:0] age_slot  [SB_DEPTH];
    logic             age_valid [SB_DEPTH];
    logic             age_match [SB_DEPTH];

    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_age
        assign age_slot[gi]  = head_q + PTR_W'(gi);
        assign age_valid[gi] = (CNT_W'(gi) < count_q);
        assign age_match[gi] = (sb_addr_q[age_slot[gi]] == word_idx);
    end

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (age_valid[i] && age_match[i]) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data_q[age_slot[i]];
            end
        end
    end

    // Draining is suppressed while reset is held so in-flight entries never reach the array.
    assign mem_we      = drain & reset;
    assign mem_waddr   = sb_addr_q[head_q];
    assign mem_wdata   = sb_data_q[head_q];
    assign SbFull      = full;
    assign OverflowErr = overflow_q;
`else
    localparam int unused_sb_depth = SB_DEPTH;

    assign mem_we      = is_store;
    assign mem_waddr   = word_idx;
    assign mem_wdata   = WriteData;
    assign fwd_hit     = 1'b0;
    assign fwd_data    = '0;
    assign SbFull      = 1'b0;
    assign OverflowErr = 1'b0;
`endif

endmodule
